// File: rtl/slope_decoder_if.sv
// Slope-stream input and reconstructed-sample output bundle for slope_decoder.
// master drives the slope flags; slave is the decoder.
interface slope_decoder_if #(
  parameter int WIDTH = 16
);
  logic                    en;
  logic                    pos;
  logic                    neg;
  logic                    eq;
  logic signed [WIDTH-1:0] dataout;
  logic        [WIDTH-1:0] step;
  logic                    peak;
  logic                    trough;
  logic                    sat;
  logic                    err;

  modport master (
    output en, pos, neg, eq,
    input  dataout, step, peak, trough, sat, err
  );

  modport slave (
    input  en, pos, neg, eq,
    output dataout, step, peak, trough, sat, err
  );
endinterface

// File: rtl/slope_decoder.sv
// Adaptive delta-modulation decoder: rebuilds a signed sample stream from
// per-cycle pos/neg/eq slope flags using a saturating accumulator and adaptive step.
module slope_decoder #(
  parameter int WIDTH    = 16,
  parameter int STEP_MIN = 1,
  parameter int STEP_MAX = 1024,
  parameter int RUN      = 2
) (
  input  logic           clk,
  input  logic           reset,
  slope_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } dir_t;

  localparam logic [WIDTH-1:0] SMIN  = WIDTH'(STEP_MIN);
  localparam logic [WIDTH-1:0] SMAX  = WIDTH'(STEP_MAX);
  localparam logic [3:0]       RUN_C = 4'(RUN);
  localparam logic [WIDTH-1:0] MAXV  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINV  = {1'b1, {(WIDTH-1){1'b0}}};

  dir_t                    dir_reg, dir_next;
  logic [3:0]              run_reg, run_next;
  logic signed [WIDTH-1:0] data_reg, data_next;
  logic [WIDTH-1:0]        step_reg, step_next;
  logic                    peak_reg, peak_next;
  logic                    trough_reg, trough_next;
  logic                    sat_reg, sat_next;
  logic                    err_reg, err_next;

  logic [2:0]       sel;
  logic             is_pos, is_neg, is_eq;
  logic [WIDTH:0]   sum_w, diff_w, upd_w;
  logic [WIDTH-1:0] step_dbl, step_half;
  logic [3:0]       run_inc;
  dir_t             dir_in;

  // Input decode and datapath candidates shared by all FSM branches.
  always_comb begin
    sel       = {bus.pos, bus.neg, bus.eq};
    is_pos    = (sel == 3'b100);
    is_neg    = (sel == 3'b010);
    is_eq     = (sel == 3'b001);
    dir_in    = is_pos ? UP : DOWN;
    sum_w     = {data_reg[WIDTH-1], data_reg} + {1'b0, step_reg};
    diff_w    = {data_reg[WIDTH-1], data_reg} - {1'b0, step_reg};
    upd_w     = is_pos ? sum_w : diff_w;
    step_dbl  = (step_reg >= SMAX) ? SMAX : (step_reg << 1);
    step_half = (step_reg <= SMIN) ? SMIN : (step_reg >> 1);
    run_inc   = (run_reg >= RUN_C) ? RUN_C : (run_reg + 4'd1);
  end

  always_comb begin
    dir_next    = dir_reg;
    run_next    = run_reg;
    data_next   = data_reg;
    step_next   = step_reg;
    peak_next   = 1'b0;
    trough_next = 1'b0;
    sat_next    = 1'b0;
    err_next    = 1'b0;
    if (bus.en) begin
      err_next = !(is_pos || is_neg || is_eq);
      if (is_pos || is_neg) begin
        // The two top bits of the widened result disagree only on overflow.
        if (upd_w[WIDTH] != upd_w[WIDTH-1]) begin
          data_next = upd_w[WIDTH] ? MINV : MAXV;
          sat_next  = 1'b1;
        end else begin
          data_next = upd_w[WIDTH-1:0];
        end
        if (dir_reg == IDLE) begin
          dir_next = dir_in;
          run_next = 4'd1;
        end else if (dir_in == dir_reg) begin
          run_next = run_inc;
          if (run_inc == RUN_C) begin
            step_next = step_dbl;
          end
        end else begin
          dir_next    = dir_in;
          run_next    = 4'd1;
          step_next   = step_half;
          peak_next   = (dir_reg == UP);
          trough_next = (dir_reg == DOWN);
        end
      end else begin
        // Flat or illegal sample: hold value, shrink step, restart the run.
        step_next = step_half;
        run_next  = 4'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dir_reg    <= IDLE;
      run_reg    <= 4'd0;
      data_reg   <= '0;
      step_reg   <= SMIN;
      peak_reg   <= 1'b0;
      trough_reg <= 1'b0;
      sat_reg    <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      dir_reg    <= dir_next;
      run_reg    <= run_next;
      data_reg   <= data_next;
      step_reg   <= step_next;
      peak_reg   <= peak_next;
      trough_reg <= trough_next;
      sat_reg    <= sat_next;
      err_reg    <= err_next;
    end
  end

  assign bus.dataout = data_reg;
  assign bus.step    = step_reg;
  assign bus.peak    = peak_reg;
  assign bus.trough  = trough_reg;
  assign bus.sat     = sat_reg;
  assign bus.err     = err_reg;

endmodule

// File: tb/tb_slope_decoder.sv
// Scoreboard bench for slope_decoder: the driver queues expected outputs per
// clocked sample and a negedge monitor pops and compares them.
module tb_slope_decoder;

  localparam int WIDTH = 16;
  localparam logic [3:0] PK = 4'b1000;
  localparam logic [3:0] TR = 4'b0100;
  localparam logic [3:0] ST = 4'b0010;
  localparam logic [3:0] ER = 4'b0001;

  typedef struct {
    logic signed [WIDTH-1:0] d;
    logic [WIDTH-1:0]        s;
    logic [3:0]              f;
    bit                      show;
    string                   name;
  } exp_t;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  exp_t x;

  slope_decoder_if #(.WIDTH(WIDTH)) bus ();

  slope_decoder #(
    .WIDTH(WIDTH), .STEP_MIN(1), .STEP_MAX(8), .RUN(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, pending=%0d", q.size());
    $fatal(1);
  end

  // Monitor: one expectation per clocked sample, checked mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      x = q.pop_front();
      checks++;
      if (bus.dataout !== x.d || bus.step !== x.s ||
          {bus.peak, bus.trough, bus.sat, bus.err} !== x.f) begin
        errors++;
        $display("FAIL %s: got dataout=%0d step=%0d flags(pk,tr,sat,err)=%b, want dataout=%0d step=%0d flags=%b",
                 x.name, bus.dataout, bus.step, {bus.peak, bus.trough, bus.sat, bus.err},
                 x.d, x.s, x.f);
      end else if (x.show) begin
        $display("ok   %s: dataout=%0d step=%0d flags=%b", x.name, bus.dataout, bus.step, x.f);
      end
    end
  end

  task automatic apply(input logic e, input logic p, input logic n, input logic z,
                       input int d, input int s, input logic [3:0] f,
                       input bit show, input string name);
    exp_t t;
    bus.en  = e;
    bus.pos = p;
    bus.neg = n;
    bus.eq  = z;
    @(posedge clk);
    t.d = WIDTH'(d);
    t.s = WIDTH'(s);
    t.f = f;
    t.show = show;
    t.name = name;
    q.push_back(t);
    #2;
  endtask

  task automatic chk_now(input string name, input int d, input int s);
    checks++;
    if (bus.dataout !== WIDTH'(d) || bus.step !== WIDTH'(s) ||
        {bus.peak, bus.trough, bus.sat, bus.err} !== 4'b0000) begin
      errors++;
      $display("FAIL %s: got dataout=%0d step=%0d flags=%b, want dataout=%0d step=%0d flags=0000",
               name, bus.dataout, bus.step, {bus.peak, bus.trough, bus.sat, bus.err}, d, s);
    end else begin
      $display("ok   %s: dataout=%0d step=%0d", name, bus.dataout, bus.step);
    end
  endtask

  int        d_exp;
  logic [3:0] f_exp;

  initial begin
    bus.en = 1'b0; bus.pos = 1'b0; bus.neg = 1'b0; bus.eq = 1'b0;
    reset = 1'b0;

    // 1. reset then hold with en low while pos is asserted
    repeat (2) @(posedge clk);
    #2;
    chk_now("reset_state", 0, 1);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) apply(1'b0, 1'b1, 1'b0, 1'b0, 0, 1, 4'b0000, 1'b1, "en0_hold");

    // 2. ramp up with step doubling and cap
    apply(1'b1, 1'b1, 1'b0, 1'b0,  1, 1, 4'b0000, 1'b1, "ramp1");
    apply(1'b1, 1'b1, 1'b0, 1'b0,  2, 2, 4'b0000, 1'b1, "ramp2");
    apply(1'b1, 1'b1, 1'b0, 1'b0,  4, 4, 4'b0000, 1'b1, "ramp3");
    apply(1'b1, 1'b1, 1'b0, 1'b0,  8, 8, 4'b0000, 1'b1, "ramp4");
    apply(1'b1, 1'b1, 1'b0, 1'b0, 16, 8, 4'b0000, 1'b1, "ramp5_cap");

    // 3. reversals, with a paused cycle dropping the peak pulse
    apply(1'b1, 1'b0, 1'b1, 1'b0,  8, 4, PK,      1'b1, "peak");
    apply(1'b0, 1'b0, 1'b1, 1'b0,  8, 4, 4'b0000, 1'b1, "pause_after_peak");
    apply(1'b1, 1'b0, 1'b1, 1'b0,  4, 8, 4'b0000, 1'b1, "down_run2");
    apply(1'b1, 1'b1, 1'b0, 1'b0, 12, 4, TR,      1'b1, "trough");

    // 4. flat and illegal samples
    apply(1'b1, 1'b0, 1'b0, 1'b1, 12, 2, 4'b0000, 1'b1, "eq1");
    apply(1'b1, 1'b0, 1'b0, 1'b1, 12, 1, 4'b0000, 1'b1, "eq2");
    apply(1'b1, 1'b0, 1'b0, 1'b1, 12, 1, 4'b0000, 1'b1, "eq3_floor");
    apply(1'b1, 1'b1, 1'b1, 1'b0, 12, 1, ER,      1'b1, "pos_and_neg");
    apply(1'b1, 1'b0, 1'b0, 1'b0, 12, 1, ER,      1'b1, "none_set");

    // 5. positive saturation: run restarts from 0 after the flat spot
    apply(1'b1, 1'b1, 1'b0, 1'b0, 13, 1, 4'b0000, 1'b1, "resume1");
    apply(1'b1, 1'b1, 1'b0, 1'b0, 14, 2, 4'b0000, 1'b1, "resume2");
    apply(1'b1, 1'b1, 1'b0, 1'b0, 16, 4, 4'b0000, 1'b1, "resume3");
    apply(1'b1, 1'b1, 1'b0, 1'b0, 20, 8, 4'b0000, 1'b1, "resume4");
    d_exp = 20;
    for (int i = 0; i < 4996; i++) begin
      d_exp += 8;
      f_exp = 4'b0000;
      if (d_exp > 32767) begin
        d_exp = 32767;
        f_exp = ST;
      end
      apply(1'b1, 1'b1, 1'b0, 1'b0, d_exp, 8, f_exp, (i == 4995), "sat_pos");
    end

    // mirror: reverse from the positive rail down to the negative rail
    apply(1'b1, 1'b0, 1'b1, 1'b0, 32759, 4, PK,      1'b1, "rail_peak");
    apply(1'b1, 1'b0, 1'b1, 1'b0, 32755, 8, 4'b0000, 1'b1, "rail_down2");
    d_exp = 32755;
    for (int i = 0; i < 8300; i++) begin
      d_exp -= 8;
      f_exp = 4'b0000;
      if (d_exp < -32768) begin
        d_exp = -32768;
        f_exp = ST;
      end
      apply(1'b1, 1'b0, 1'b1, 1'b0, d_exp, 8, f_exp, (i == 8299), "sat_neg");
    end

    // 6. reset from the negative rail, ramp to 40, then asynchronous reset mid-cycle
    @(negedge clk); #1;
    bus.en = 1'b0;
    reset = 1'b0;
    #1;
    chk_now("async_reset_from_rail", 0, 1);
    @(posedge clk); #2;
    reset = 1'b1;
    apply(1'b1, 1'b1, 1'b0, 1'b0,  1, 1, 4'b0000, 1'b1, "rst_ramp1_no_trough");
    apply(1'b1, 1'b1, 1'b0, 1'b0,  2, 2, 4'b0000, 1'b1, "rst_ramp2");
    apply(1'b1, 1'b1, 1'b0, 1'b0,  4, 4, 4'b0000, 1'b1, "rst_ramp3");
    apply(1'b1, 1'b1, 1'b0, 1'b0,  8, 8, 4'b0000, 1'b1, "rst_ramp4");
    apply(1'b1, 1'b1, 1'b0, 1'b0, 16, 8, 4'b0000, 1'b1, "rst_ramp5");
    apply(1'b1, 1'b1, 1'b0, 1'b0, 24, 8, 4'b0000, 1'b1, "rst_ramp6");
    apply(1'b1, 1'b1, 1'b0, 1'b0, 32, 8, 4'b0000, 1'b1, "rst_ramp7");
    apply(1'b1, 1'b1, 1'b0, 1'b0, 40, 8, 4'b0000, 1'b1, "rst_ramp8");
    @(negedge clk); #1;
    bus.en = 1'b0;
    reset = 1'b0;
    #1;
    chk_now("async_reset_mid_ramp", 0, 1);
    @(posedge clk); #2;
    reset = 1'b1;
    apply(1'b1, 1'b1, 1'b0, 1'b0, 1, 1, 4'b0000, 1'b1, "post_reset_pos");
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 4'b0000, 1'b1, "post_reset_idle");

    @(negedge clk); #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
